alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX pipeline register and ALU operand/control generator; drives the EX-stage ALU inputs SrcAE, SrcBE, ALUControlE and funct3E.
- Decodes opcode/funct3/funct7b5 in D and registers controls and operands into E.
- Applies M/W forwarding to the operands combinationally in E.
- Supports a stall (hold) and a flush (bubble) from the hazard unit.

Parameters:
XLEN, 32, datapath width
ALUCTRL_W, 5, ALUControl width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
StallE  in  1  hold E register contents
FlushE  in  1  load bubble into E
ValidD  in  1  D holds a real instruction
InstrD  in  32  instruction word (opcode[6:0], funct3[14:12], funct7b5[30], rd[11:7], rs1[19:15], rs2[24:20])
PCD  in  XLEN  instruction PC
RD1D, RD2D  in  XLEN  register file read data
ImmExtD  in  XLEN  sign-extended immediate
ForwardAE, ForwardBE  in  2  00 reg, 01 ResultW, 10 ALUResultM, 11 treated as 00
ResultW, ALUResultM  in  XLEN  forwarding sources
SrcAE, SrcBE  out  XLEN  ALU operands
ALUControlE  out  ALUCTRL_W  ALU operation
funct3E  out  3  branch condition to ALU
WriteDataE  out  XLEN  forwarded RD2, store data
PCE  out  XLEN; RdE, Rs1E, Rs2E  out  5 each
RegWriteE, MemWriteE, BranchE, JumpE, ValidE, IllegalE  out  1 each

Behaviour:
- Reset (async, rst_n=0): all E registers clear immediately. ValidE=0, RegWriteE=MemWriteE=BranchE=JumpE=IllegalE=0, ALUControlE=00000, funct3E=0, RdE=Rs1E=Rs2E=0, PCE=0, stored operands 0. SrcAE/SrcBE/WriteDataE therefore read 0 while forward selects are 00.
- Latency: 1 cycle from D inputs to E outputs. Forward muxes are combinational in E; there is no extra latency.
- Priority per rising edge: FlushE > StallE > load. Flush loads a bubble (same values as reset). Stall holds every E register. FlushE and StallE high together give a bubble.
- ValidD=0 while loading: a bubble is loaded.
- ALUControl encoding: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 xor, 00101 sll, 00110 srl, 00111 sra, 01000 slt, 01001 sltu, 01010 passB. All other codes are unused.
- Decode:
  - R 0110011: funct3 → op; funct3=000 with funct7b5=1 → sub; funct3=101 with funct7b5=1 → sra.
  - I 0010011: as R, but funct3=000 is always add; srai uses funct7b5.
  - Load 0000011: add, RegWrite.
  - Store 0100011: add, MemWrite.
  - Branch 1100011: sub, Branch, funct3 passed through.
  - jal 1101111, jalr 1100111: add, Jump, RegWrite.
  - lui 0110111: passB.
  - auipc 0010111: add with SrcA=PC.
- Illegal opcode with ValidD=1: IllegalE=1, ValidE=1, all other controls zeroed, ALUControlE=00000.
- SrcAE: PCE for auipc; otherwise the forwarded RD1.
- SrcBE: forwarded RD2 for R-type and branch; otherwise the registered immediate.
- WriteDataE: always the forwarded RD2.
- funct3E is 0 for non-branch instructions.
- rd=x0: RegWriteE is forced to 0.
- Rs1E/Rs2E register the fields regardless of opcode. The hazard unit qualifies them.

Decomposition:
- Shared package riscv_pkg: ALUControl localparams (ALU_ADD..ALU_PASSB), opcode localparams, forward-select codes.
- One sub-module, alu_ctrl_decoder: combinational opcode/funct3/funct7b5 → ALUControl, control bits, Illegal.
- alu_issue_stage holds the registers and forward muxes.

Test Plan:
- Reset: assert rst_n=0 mid-cycle while loaded → outputs clear without waiting for a clock edge; ALUControlE=00000, ValidE=0.
- R-type sub x3,x1,x2, RD1D=10, RD2D=3, Forward 00/00 → next cycle SrcAE=10, SrcBE=3, ALUControlE=00001, RegWriteE=1, RdE=3. Repeat with funct7b5=0 → 00000.
- Forwarding: SrcAE=10 after load; then ForwardAE=10 with ALUResultM=0x55 → SrcAE=0x55 same cycle. ForwardBE=01 with ResultW=7 on a branch → SrcBE=7.
- bne decode: funct3=001, RD1D=5, RD2D=5 → ALUControlE=00001, funct3E=001, BranchE=1, RegWriteE=0. srai with funct7b5=1, Imm=4 → 00111, SrcBE=4.
- Stall/flush: load addi, StallE=1 for 2 cycles with new D inputs → outputs unchanged. FlushE=1 with StallE=1 → bubble next edge.
- lui/auipc/illegal:
  - lui Imm=0x12345000 → 01010, SrcBE=0x12345000.
  - auipc, PCD=0x100 → SrcAE=0x100.
  - opcode 1111111 → IllegalE=1, RegWriteE=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: ALU operation codes, opcodes, forward selects
// and the decoded control payload carried from D into E.
package riscv_pkg;

   localparam int unsigned ALU_W = 5;

   localparam logic [ALU_W-1:0] ALU_ADD   = 5'b00000;
   localparam logic [ALU_W-1:0] ALU_SUB   = 5'b00001;
   localparam logic [ALU_W-1:0] ALU_AND   = 5'b00010;
   localparam logic [ALU_W-1:0] ALU_OR    = 5'b00011;
   localparam logic [ALU_W-1:0] ALU_XOR   = 5'b00100;
   localparam logic [ALU_W-1:0] ALU_SLL   = 5'b00101;
   localparam logic [ALU_W-1:0] ALU_SRL   = 5'b00110;
   localparam logic [ALU_W-1:0] ALU_SRA   = 5'b00111;
   localparam logic [ALU_W-1:0] ALU_SLT   = 5'b01000;
   localparam logic [ALU_W-1:0] ALU_SLTU  = 5'b01001;
   localparam logic [ALU_W-1:0] ALU_PASSB = 5'b01010;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_W   = 2'b01;
   localparam logic [1:0] FWD_M   = 2'b10;

   // Decoded controls; src_a_pc selects PC for operand A, src_b_reg selects RD2 for operand B
   typedef struct packed {
      logic [ALU_W-1:0] alu_ctrl;
      logic             reg_write;
      logic             mem_write;
      logic             branch;
      logic             jump;
      logic             illegal;
      logic             src_a_pc;
      logic             src_b_reg;
   } dec_ctrl_t;

endpackage

// File: rtl/alu_ctrl_decoder.sv
// Combinational D-stage decoder: opcode/funct3/funct7b5 to ALU operation and control bits.
module alu_ctrl_decoder
   import riscv_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   output dec_ctrl_t  o_ctrl_c
);

   logic [ALU_W-1:0] w_arith;

   // funct3 to ALU op shared by R and I types; funct7b5 picks sra over srl
   always_comb begin
      w_arith = ALU_ADD;
      case (i_funct3)
         3'b000:  w_arith = ALU_ADD;
         3'b001:  w_arith = ALU_SLL;
         3'b010:  w_arith = ALU_SLT;
         3'b011:  w_arith = ALU_SLTU;
         3'b100:  w_arith = ALU_XOR;
         3'b101:  w_arith = i_funct7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  w_arith = ALU_OR;
         3'b111:  w_arith = ALU_AND;
         default: w_arith = ALU_ADD;
      endcase
   end

   // Per-opcode control generation; unknown opcodes only raise illegal
   always_comb begin
      o_ctrl_c = '0;
      case (i_opcode)
         OP_R: begin
            o_ctrl_c.alu_ctrl  = (i_funct3 == 3'b000 && i_funct7b5) ? ALU_SUB : w_arith;
            o_ctrl_c.reg_write = 1'b1;
            o_ctrl_c.src_b_reg = 1'b1;
         end
         OP_I: begin
            o_ctrl_c.alu_ctrl  = w_arith;
            o_ctrl_c.reg_write = 1'b1;
         end
         OP_LOAD: begin
            o_ctrl_c.alu_ctrl  = ALU_ADD;
            o_ctrl_c.reg_write = 1'b1;
         end
         OP_STORE: begin
            o_ctrl_c.alu_ctrl  = ALU_ADD;
            o_ctrl_c.mem_write = 1'b1;
         end
         OP_BRANCH: begin
            o_ctrl_c.alu_ctrl  = ALU_SUB;
            o_ctrl_c.branch    = 1'b1;
            o_ctrl_c.src_b_reg = 1'b1;
         end
         OP_JAL, OP_JALR: begin
            o_ctrl_c.alu_ctrl  = ALU_ADD;
            o_ctrl_c.jump      = 1'b1;
            o_ctrl_c.reg_write = 1'b1;
         end
         OP_LUI: begin
            o_ctrl_c.alu_ctrl  = ALU_PASSB;
            o_ctrl_c.reg_write = 1'b1;
         end
         OP_AUIPC: begin
            o_ctrl_c.alu_ctrl  = ALU_ADD;
            o_ctrl_c.reg_write = 1'b1;
            o_ctrl_c.src_a_pc  = 1'b1;
         end
         default: o_ctrl_c.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register plus E-stage forwarding muxes driving the ALU operands.
module alu_issue_stage
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned ALUCTRL_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 StallE,
   input  logic                 FlushE,
   input  logic                 ValidD,
   input  logic [31:0]          InstrD,
   input  logic [XLEN-1:0]      PCD,
   input  logic [XLEN-1:0]      RD1D,
   input  logic [XLEN-1:0]      RD2D,
   input  logic [XLEN-1:0]      ImmExtD,
   input  logic [1:0]           ForwardAE,
   input  logic [1:0]           ForwardBE,
   input  logic [XLEN-1:0]      ResultW,
   input  logic [XLEN-1:0]      ALUResultM,
   output logic [XLEN-1:0]      SrcAE,
   output logic [XLEN-1:0]      SrcBE,
   output logic [ALUCTRL_W-1:0] ALUControlE,
   output logic [2:0]           funct3E,
   output logic [XLEN-1:0]      WriteDataE,
   output logic [XLEN-1:0]      PCE,
   output logic [4:0]           RdE,
   output logic [4:0]           Rs1E,
   output logic [4:0]           Rs2E,
   output logic                 RegWriteE,
   output logic                 MemWriteE,
   output logic                 BranchE,
   output logic                 JumpE,
   output logic                 ValidE,
   output logic                 IllegalE
);

   dec_ctrl_t             w_ctrl;
   logic                  w_unused;
   logic [XLEN-1:0]       w_fwd_a;
   logic [XLEN-1:0]       w_fwd_b;

   logic                  r_valid;
   logic                  r_reg_write;
   logic                  r_mem_write;
   logic                  r_branch;
   logic                  r_jump;
   logic                  r_illegal;
   logic                  r_src_a_pc;
   logic                  r_src_b_reg;
   logic [ALUCTRL_W-1:0]  r_alu_ctrl;
   logic [2:0]            r_funct3;
   logic [4:0]            r_rd;
   logic [4:0]            r_rs1;
   logic [4:0]            r_rs2;
   logic [XLEN-1:0]       r_pc;
   logic [XLEN-1:0]       r_rd1;
   logic [XLEN-1:0]       r_rd2;
   logic [XLEN-1:0]       r_imm;

   assign w_unused = ^{InstrD[31], InstrD[29:25]};

   alu_ctrl_decoder u_dec (
      .i_opcode   (InstrD[6:0]),
      .i_funct3   (InstrD[14:12]),
      .i_funct7b5 (InstrD[30]),
      .o_ctrl_c   (w_ctrl)
   );

   // E register: flush or an invalid D slot loads a bubble, stall holds, otherwise load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_write <= 1'b0;
         r_branch    <= 1'b0;
         r_jump      <= 1'b0;
         r_illegal   <= 1'b0;
         r_src_a_pc  <= 1'b0;
         r_src_b_reg <= 1'b0;
         r_alu_ctrl  <= '0;
         r_funct3    <= '0;
         r_rd        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_pc        <= '0;
         r_rd1       <= '0;
         r_rd2       <= '0;
         r_imm       <= '0;
      end else if (FlushE || (!StallE && !ValidD)) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_write <= 1'b0;
         r_branch    <= 1'b0;
         r_jump      <= 1'b0;
         r_illegal   <= 1'b0;
         r_src_a_pc  <= 1'b0;
         r_src_b_reg <= 1'b0;
         r_alu_ctrl  <= '0;
         r_funct3    <= '0;
         r_rd        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_pc        <= '0;
         r_rd1       <= '0;
         r_rd2       <= '0;
         r_imm       <= '0;
      end else if (!StallE) begin
         r_valid     <= 1'b1;
         r_reg_write <= w_ctrl.reg_write && (InstrD[11:7] != 5'd0);
         r_mem_write <= w_ctrl.mem_write;
         r_branch    <= w_ctrl.branch;
         r_jump      <= w_ctrl.jump;
         r_illegal   <= w_ctrl.illegal;
         r_src_a_pc  <= w_ctrl.src_a_pc;
         r_src_b_reg <= w_ctrl.src_b_reg;
         r_alu_ctrl  <= ALUCTRL_W'(w_ctrl.alu_ctrl);
         r_funct3    <= w_ctrl.branch ? InstrD[14:12] : 3'b000;
         r_rd        <= InstrD[11:7];
         r_rs1       <= InstrD[19:15];
         r_rs2       <= InstrD[24:20];
         r_pc        <= PCD;
         r_rd1       <= RD1D;
         r_rd2       <= RD2D;
         r_imm       <= ImmExtD;
      end
   end

   // Forwarding muxes; select 11 falls back to the registered operand
   always_comb begin
      w_fwd_a = r_rd1;
      w_fwd_b = r_rd2;
      case (ForwardAE)
         FWD_W:   w_fwd_a = ResultW;
         FWD_M:   w_fwd_a = ALUResultM;
         default: w_fwd_a = r_rd1;
      endcase
      case (ForwardBE)
         FWD_W:   w_fwd_b = ResultW;
         FWD_M:   w_fwd_b = ALUResultM;
         default: w_fwd_b = r_rd2;
      endcase
   end

   assign SrcAE       = r_src_a_pc  ? r_pc    : w_fwd_a;
   assign SrcBE       = r_src_b_reg ? w_fwd_b : r_imm;
   assign WriteDataE  = w_fwd_b;
   assign ALUControlE = r_alu_ctrl;
   assign funct3E     = r_funct3;
   assign PCE         = r_pc;
   assign RdE         = r_rd;
   assign Rs1E        = r_rs1;
   assign Rs2E        = r_rs2;
   assign RegWriteE   = r_reg_write;
   assign MemWriteE   = r_mem_write;
   assign BranchE     = r_branch;
   assign JumpE       = r_jump;
   assign ValidE      = r_valid;
   assign IllegalE    = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a randomized
// run against a model that stores the raw D-stage slot and decodes it on read.
module tb_alu_issue_stage;

   localparam int unsigned OUT_W = 157;

   localparam logic [6:0] T_R = 7'b0110011, T_I = 7'b0010011, T_LD = 7'b0000011,
                          T_ST = 7'b0100011, T_BR = 7'b1100011, T_JAL = 7'b1101111,
                          T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, valid_d;
   logic [31:0] instr_d, pc_d, rd1_d, rd2_d, imm_d, result_w, alu_result_m;
   logic [1:0]  fwd_a, fwd_b;

   logic [31:0] SrcAE, SrcBE, WriteDataE, PCE;
   logic [4:0]  ALUControlE, RdE, Rs1E, Rs2E;
   logic [2:0]  funct3E;
   logic        RegWriteE, MemWriteE, BranchE, JumpE, ValidE, IllegalE;
   logic [OUT_W-1:0] w_obs;

   int checks = 0;
   int errors = 0;

   // Model state: the D slot captured at the last load, or all zeros for a bubble
   logic        m_v;
   logic [31:0] m_instr, m_pc, m_rd1, m_rd2, m_imm;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk(clk), .rst_n(rst_n), .StallE(stall), .FlushE(flush), .ValidD(valid_d),
      .InstrD(instr_d), .PCD(pc_d), .RD1D(rd1_d), .RD2D(rd2_d), .ImmExtD(imm_d),
      .ForwardAE(fwd_a), .ForwardBE(fwd_b), .ResultW(result_w), .ALUResultM(alu_result_m),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE), .funct3E(funct3E),
      .WriteDataE(WriteDataE), .PCE(PCE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
      .ValidE(ValidE), .IllegalE(IllegalE)
   );

   assign w_obs = {SrcAE, SrcBE, ALUControlE, funct3E, WriteDataE, PCE, RdE, Rs1E, Rs2E,
                   RegWriteE, MemWriteE, BranchE, JumpE, ValidE, IllegalE};

   function automatic logic [31:0] mk(logic [6:0] op, logic [2:0] f3, logic f7b5,
                                      logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
      return {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [4:0] m_arith(logic [2:0] f3, logic f7b5, logic is_r);
      logic [4:0] tbl [8];
      tbl = '{5'd0, 5'd5, 5'd8, 5'd9, 5'd4, 5'd6, 5'd3, 5'd2};
      if (f3 == 3'd5 && f7b5) return 5'd7;
      if (f3 == 3'd0 && f7b5 && is_r) return 5'd1;
      return tbl[f3];
   endfunction

   function automatic logic [31:0] m_fwd(logic [1:0] sel, logic [31:0] regv,
                                         logic [31:0] w, logic [31:0] m);
      if (sel == 2'b01) return w;
      if (sel == 2'b10) return m;
      return regv;
   endfunction

   // Expected E outputs from the stored slot and the live forwarding inputs
   function automatic logic [OUT_W-1:0] m_expect();
      logic [31:0] a, b;
      logic [4:0]  alu;
      logic        rw, mw, br, jp, il, use_pc, use_rs2;
      alu = 5'd0; rw = 0; mw = 0; br = 0; jp = 0; il = 0; use_pc = 0; use_rs2 = 0;
      a = m_fwd(fwd_a, m_rd1, result_w, alu_result_m);
      b = m_fwd(fwd_b, m_rd2, result_w, alu_result_m);
      if (m_v) begin
         case (m_instr[6:0])
            T_R:           begin alu = m_arith(m_instr[14:12], m_instr[30], 1'b1); rw = 1; use_rs2 = 1; end
            T_I:           begin alu = m_arith(m_instr[14:12], m_instr[30], 1'b0); rw = 1; end
            T_LD:          rw = 1;
            T_ST:          mw = 1;
            T_BR:          begin alu = 5'd1; br = 1; use_rs2 = 1; end
            T_JAL, T_JALR: begin jp = 1; rw = 1; end
            T_LUI:         begin alu = 5'd10; rw = 1; end
            T_AUIPC:       begin rw = 1; use_pc = 1; end
            default:       il = 1;
         endcase
         if (m_instr[11:7] == 5'd0) rw = 0;
      end
      return {use_pc ? m_pc : a, use_rs2 ? b : m_imm, alu, br ? m_instr[14:12] : 3'd0, b, m_pc,
              m_instr[11:7], m_instr[19:15], m_instr[24:20], rw, mw, br, jp, m_v, il};
   endfunction

   task automatic m_bubble();
      m_v = 0; m_instr = '0; m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
   endtask

   task automatic set_d(logic v, logic [31:0] ins, logic [31:0] pc, logic [31:0] r1,
                        logic [31:0] r2, logic [31:0] imm);
      valid_d = v; instr_d = ins; pc_d = pc; rd1_d = r1; rd2_d = r2; imm_d = imm;
   endtask

   // One rising edge; the model applies flush > stall > load using the inputs at the edge
   task automatic tick();
      @(posedge clk);
      if (flush || (!stall && !valid_d)) m_bubble();
      else if (!stall) begin
         m_v = 1; m_instr = instr_d; m_pc = pc_d; m_rd1 = rd1_d; m_rd2 = rd2_d; m_imm = imm_d;
      end
      #1;
   endtask

   task automatic test_reset();
      set_d(1, mk(T_I, 3'd0, 0, 5'd5, 5'd1, 5'd0), 32'h40, 32'h11, 32'h22, 32'h33);
      #2 rst_n = 1'b1;
      tick();
      checks++;
      if (ValidE !== 1'b1 || RdE !== 5'd5) begin
         errors++; $display("FAIL reset_preload valid=%b rd=%0d exp valid=1 rd=5", ValidE, RdE);
      end
      #3 rst_n = 1'b0;
      m_bubble();
      #1;
      checks++;
      if (w_obs !== '0) begin
         errors++; $display("FAIL reset_async_clear got %h exp 0", w_obs);
      end
      checks++;
      if (ALUControlE !== 5'b00000 || ValidE !== 1'b0) begin
         errors++; $display("FAIL reset_alu_valid alu=%b valid=%b exp 00000/0", ALUControlE, ValidE);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_rtype();
      set_d(1, mk(T_R, 3'd0, 1, 5'd3, 5'd1, 5'd2), 32'h200, 32'd10, 32'd3, 32'hABCD);
      tick();
      checks++;
      if ({SrcAE, SrcBE, ALUControlE, RegWriteE, RdE} !== {32'd10, 32'd3, 5'b00001, 1'b1, 5'd3}) begin
         errors++; $display("FAIL rtype_sub a=%0d b=%0d alu=%b rw=%b rd=%0d exp 10 3 00001 1 3",
                            SrcAE, SrcBE, ALUControlE, RegWriteE, RdE);
      end
      instr_d = mk(T_R, 3'd0, 0, 5'd3, 5'd1, 5'd2);
      tick();
      checks++;
      if ({SrcAE, SrcBE, ALUControlE} !== {32'd10, 32'd3, 5'b00000}) begin
         errors++; $display("FAIL rtype_add a=%0d b=%0d alu=%b exp 10 3 00000", SrcAE, SrcBE, ALUControlE);
      end
      instr_d = mk(T_I, 3'd0, 0, 5'd0, 5'd1, 5'd0);
      tick();
      checks++;
      if (RegWriteE !== 1'b0 || ValidE !== 1'b1) begin
         errors++; $display("FAIL rd_x0 rw=%b valid=%b exp 0 1", RegWriteE, ValidE);
      end
   endtask

   task automatic test_forwarding();
      set_d(1, mk(T_R, 3'd0, 0, 5'd4, 5'd1, 5'd2), 32'h300, 32'd10, 32'd20, 32'd0);
      tick();
      checks++;
      if (SrcAE !== 32'd10) begin
         errors++; $display("FAIL fwd_a_reg got %h exp 0000000a", SrcAE);
      end
      fwd_a = 2'b10; alu_result_m = 32'h55;
      #1;
      checks++;
      if (SrcAE !== 32'h55) begin
         errors++; $display("FAIL fwd_a_mem got %h exp 00000055", SrcAE);
      end
      fwd_a = 2'b11;
      #1;
      checks++;
      if (SrcAE !== 32'd10) begin
         errors++; $display("FAIL fwd_a_sel11 got %h exp 0000000a", SrcAE);
      end
      fwd_a = 2'b00;
      set_d(1, mk(T_BR, 3'd0, 0, 5'd0, 5'd1, 5'd2), 32'h310, 32'd1, 32'd99, 32'h10);
      fwd_b = 2'b01; result_w = 32'd7;
      tick();
      checks++;
      if (SrcBE !== 32'd7 || WriteDataE !== 32'd7) begin
         errors++; $display("FAIL fwd_b_wb srcb=%0d wd=%0d exp 7 7", SrcBE, WriteDataE);
      end
      fwd_b = 2'b00;
   endtask

   task automatic test_branch_srai();
      set_d(1, mk(T_BR, 3'b001, 0, 5'd9, 5'd1, 5'd2), 32'h400, 32'd5, 32'd5, 32'h8);
      tick();
      checks++;
      if ({ALUControlE, funct3E, BranchE, RegWriteE, SrcAE, SrcBE} !==
          {5'b00001, 3'b001, 1'b1, 1'b0, 32'd5, 32'd5}) begin
         errors++; $display("FAIL bne alu=%b f3=%b br=%b rw=%b a=%0d b=%0d exp 00001 001 1 0 5 5",
                            ALUControlE, funct3E, BranchE, RegWriteE, SrcAE, SrcBE);
      end
      set_d(1, mk(T_I, 3'b101, 1, 5'd8, 5'd1, 5'd4), 32'h404, 32'h80000000, 32'd77, 32'd4);
      tick();
      checks++;
      if ({ALUControlE, SrcBE, funct3E} !== {5'b00111, 32'd4, 3'b000}) begin
         errors++; $display("FAIL srai alu=%b b=%0d f3=%b exp 00111 4 000", ALUControlE, SrcBE, funct3E);
      end
   endtask

   task automatic test_stall_flush();
      set_d(1, mk(T_I, 3'd0, 0, 5'd6, 5'd2, 5'd0), 32'h500, 32'd11, 32'd0, 32'd20);
      tick();
      for (int i = 0; i < 2; i++) begin
         stall = 1'b1;
         set_d(1, mk(T_R, 3'd7, 1, 5'd12 + 5'(i), 5'd3, 5'd4), 32'h600, 32'd1, 32'd2, 32'd3);
         tick();
         checks++;
         if ({SrcAE, SrcBE, ALUControlE, RdE, PCE, ValidE, RegWriteE} !==
             {32'd11, 32'd20, 5'b00000, 5'd6, 32'h500, 1'b1, 1'b1}) begin
            errors++; $display("FAIL stall_hold[%0d] a=%0d b=%0d alu=%b rd=%0d pc=%h exp 11 20 00000 6 00000500",
                               i, SrcAE, SrcBE, ALUControlE, RdE, PCE);
         end
      end
      flush = 1'b1;
      tick();
      checks++;
      if (w_obs !== '0) begin
         errors++; $display("FAIL flush_with_stall got %h exp 0", w_obs);
      end
      flush = 1'b0; stall = 1'b0;
      set_d(1, mk(T_ST, 3'd2, 0, 5'd1, 5'd2, 5'd3), 32'h700, 32'd5, 32'd6, 32'd7);
      tick();
      valid_d = 1'b0;
      tick();
      checks++;
      if (ValidE !== 1'b0 || MemWriteE !== 1'b0 || PCE !== 32'd0) begin
         errors++; $display("FAIL invalid_d valid=%b mw=%b pc=%h exp 0 0 0", ValidE, MemWriteE, PCE);
      end
   endtask

   task automatic test_lui_auipc_illegal();
      set_d(1, mk(T_LUI, 3'd0, 0, 5'd7, 5'd0, 5'd0), 32'h800, 32'd1, 32'd2, 32'h12345000);
      tick();
      checks++;
      if (ALUControlE !== 5'b01010 || SrcBE !== 32'h12345000) begin
         errors++; $display("FAIL lui alu=%b b=%h exp 01010 12345000", ALUControlE, SrcBE);
      end
      set_d(1, mk(T_AUIPC, 3'd0, 0, 5'd7, 5'd0, 5'd0), 32'h100, 32'hDEAD, 32'd2, 32'h1000);
      tick();
      checks++;
      if (SrcAE !== 32'h100 || ALUControlE !== 5'b00000 || SrcBE !== 32'h1000) begin
         errors++; $display("FAIL auipc a=%h alu=%b b=%h exp 00000100 00000 00001000", SrcAE, ALUControlE, SrcBE);
      end
      set_d(1, mk(7'b1111111, 3'd3, 1, 5'd5, 5'd1, 5'd2), 32'h900, 32'd1, 32'd2, 32'd3);
      tick();
      checks++;
      if ({IllegalE, ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ALUControlE, funct3E} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000}) begin
         errors++; $display("FAIL illegal il=%b v=%b rw=%b mw=%b br=%b j=%b alu=%b f3=%b exp 1 1 0 0 0 0 00000 000",
                            IllegalE, ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ALUControlE, funct3E);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [10];
      ops = '{T_R, T_I, T_LD, T_ST, T_BR, T_JAL, T_JALR, T_LUI, T_AUIPC, 7'b0};
      for (int n = 0; n < 300; n++) begin
         logic [6:0] op;
         op = ops[$urandom_range(0, 9)];
         if (op == 7'b0) op = 7'($urandom);
         set_d(($urandom_range(0, 7) != 0), {$urandom} & 32'hFFFFFF80 | 32'(op),
               $urandom, $urandom, $urandom, $urandom);
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 7) == 0);
         fwd_a = 2'($urandom); fwd_b = 2'($urandom);
         result_w = $urandom; alu_result_m = $urandom;
         tick();
         checks++;
         if (w_obs !== m_expect()) begin
            errors++; $display("FAIL random_edge[%0d] got %h exp %h", n, w_obs, m_expect());
         end
         fwd_a = 2'($urandom); fwd_b = 2'($urandom);
         result_w = $urandom; alu_result_m = $urandom;
         #1;
         checks++;
         if (w_obs !== m_expect()) begin
            errors++; $display("FAIL random_fwd[%0d] got %h exp %h", n, w_obs, m_expect());
         end
      end
      stall = 1'b0; flush = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      fwd_a = 2'b00; fwd_b = 2'b00; result_w = '0; alu_result_m = '0;
      set_d(0, '0, '0, '0, '0, '0);
      m_bubble();
      #1;
      checks++;
      if (w_obs !== '0) begin
         errors++; $display("FAIL reset_initial got %h exp 0", w_obs);
      end
      test_reset();
      test_rtype();
      test_forwarding();
      test_branch_srai();
      test_stall_flush();
      test_lui_auipc_illegal();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
